// File: rtl/instr_fetch_if.sv
// Request/response and decode handshake bundle for the instruction fetch stage.
// The master modport is the fetch stage; the slave modport is its memory/decode environment.
interface instr_fetch_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output req_valid, req_addr, instr_valid, instr, instr_pc,
        input  req_ready, resp_valid, resp_data, instr_ready
    );

    modport slave (
        input  req_valid, req_addr, instr_valid, instr, instr_pc,
        output req_ready, resp_valid, resp_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited memory requests, in-order response FIFO, redirect flush.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-starvation counter on stall_cnt.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    instr_fetch_if.master bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [31:0]     fifo_instr_q [QUEUE_DEPTH];
    logic [31:0]     fifo_pc_q    [QUEUE_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            credit_ok, fire, push, pop;

    // Credit counts queued words plus in-flight requests, so every response has a slot.
    assign credit_ok     = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;
    assign bus.req_valid = (state_q == FETCH) && !redirect_valid && credit_ok;
    assign bus.req_addr  = pc_q;
    assign fire          = bus.req_valid && bus.req_ready;

    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        discard_d     = discard_q;
        push          = 1'b0;
        pop           = 1'b0;
        outstanding_d = outstanding_q + CW'(fire) - CW'(bus.resp_valid && outstanding_q != '0);

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            discard_d = outstanding_d;
        end else begin
            if (fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (bus.resp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                end
            end
            pop = bus.instr_valid && bus.instr_ready;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            if (discard_d != '0)  state_d = DRAIN;
            else if (fetch_en)    state_d = FETCH;
            else                  state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en && discard_q == '0) state_d = FETCH;
                FETCH:   if (!fetch_en) state_d = IDLE;
                DRAIN:   if (discard_d == '0) state_d = fetch_en ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Storage needs no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_instr_q[wr_ptr_q] <= bus.resp_data;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (bus.instr_ready && !bus.instr_valid && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based model of the fetch front end.
// Build with FETCH_STALL_CNT_EN defined to also exercise stall_cnt.
module tb_instr_fetch;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; bit stale;} flight_t;
    typedef struct {logic [31:0] ins; logic [31:0] pc;} entry_t;
    typedef struct {logic [31:0] addr; int due;} mem_t;

    int total = 0, bad = 0, cyc = 0, last_due = 0;
    int p_fetch, p_ready, p_instr, p_redir, p_rst, lat_min, lat_max;
    bit ctl_rst = 1'b0, force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;

    flight_t     m_fl[$];
    entry_t      m_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc = 32'h0;
    int          m_phase = M_IDLE;
    logic [31:0] m_stall = 32'h0;
    logic        m_rv;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_instr, s_ipc, s_stall;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every DUT output against what the model says this cycle must show.
    task automatic checkOutput();
        m_rv = (m_phase == M_RUN) && !redirect_valid && (m_q.size() + m_fl.size() < DEPTH);
        s_rv    = bus.req_valid;
        s_addr  = bus.req_addr;
        s_iv    = bus.instr_valid;
        s_instr = bus.instr;
        s_ipc   = bus.instr_pc;
        chk("req_valid", {31'h0, s_rv}, {31'h0, m_rv});
        chk("req_addr", s_addr, m_pc);
        chk("instr_valid", {31'h0, s_iv}, {31'h0, m_q.size() > 0});
        chk("instr", s_instr, m_q.size() > 0 ? m_q[0].ins : 32'h0);
        chk("instr_pc", s_ipc, m_q.size() > 0 ? m_q[0].pc : 32'h0);
`ifdef FETCH_STALL_CNT_EN
        s_stall = stall_cnt;
        chk("stall_cnt", s_stall, m_stall);
`else
        s_stall = 32'h0;
`endif
    endtask

    // Advance the memory and the reference model by one clock using this cycle's inputs.
    task automatic updateModel();
        flight_t h;
        int      lat, due, stale_left;
        bit      was_empty;
        was_empty = (m_q.size() == 0);

        if (rst) begin
            mem_q.delete();
            last_due = 0;
        end else begin
            if (bus.resp_valid) void'(mem_q.pop_front());
            if (s_rv && bus.req_ready) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: s_addr, due: due});
            end
        end

        if (rst) m_stall = 32'h0;
        else if (bus.instr_ready && was_empty && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;

        if (rst) begin
            m_fl.delete();
            m_q.delete();
            m_pc = 32'h0;
            m_phase = M_IDLE;
        end else if (redirect_valid) begin
            if (bus.resp_valid && m_fl.size() > 0) void'(m_fl.pop_front());
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_q.delete();
            m_pc = redirect_pc;
            m_phase = (m_fl.size() > 0) ? M_DRAIN : (fetch_en ? M_RUN : M_IDLE);
        end else begin
            if (m_q.size() > 0 && bus.instr_ready) void'(m_q.pop_front());
            if (bus.resp_valid && m_fl.size() > 0) begin
                h = m_fl.pop_front();
                if (!h.stale) m_q.push_back('{ins: word(h.pc), pc: h.pc});
            end
            if (m_rv && bus.req_ready) begin
                m_fl.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            stale_left = 0;
            foreach (m_fl[i]) if (m_fl[i].stale) stale_left++;
            case (m_phase)
                M_IDLE:  if (fetch_en && stale_left == 0) m_phase = M_RUN;
                M_RUN:   if (!fetch_en) m_phase = M_IDLE;
                default: if (stale_left == 0) m_phase = fetch_en ? M_RUN : M_IDLE;
            endcase
        end
    endtask

    // One clock: drive inputs after the edge, settle, then check and step the model.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        rst            = ctl_rst || (int'($urandom_range(999)) < p_rst);
        fetch_en       = int'($urandom_range(99)) < p_fetch;
        redirect_valid = force_redir || (int'($urandom_range(99)) < p_redir);
        if (force_redir)           redirect_pc = force_pc;
        else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0;
        else                       redirect_pc = $urandom & 32'hFFFF_FFFC;
        force_redir     = 1'b0;
        bus.req_ready   = int'($urandom_range(99)) < p_ready;
        bus.instr_ready = int'($urandom_range(99)) < p_instr;
        bus.resp_valid  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.resp_data   = bus.resp_valid ? word(mem_q[0].addr) : $urandom;
        #1;
        checkOutput();
        updateModel();
    endtask

    task automatic doReset(input int n);
        ctl_rst = 1'b1;
        repeat (n) applyStimulus();
        ctl_rst = 1'b0;
    endtask

    initial begin
        int          first_k, fires, seen;
        logic [31:0] pc0, pc1, w0, w1;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
        bus.resp_data = 32'h0; bus.instr_ready = 1'b0;
        p_fetch = 100; p_ready = 100; p_instr = 100; p_redir = 0; p_rst = 0;
        lat_min = 1; lat_max = 1;

        // Streaming with a 1-cycle memory: first word 3 cycles after reset release.
        doReset(3);
        first_k = -1; pc0 = '1; pc1 = '1; w0 = '1; w1 = '1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            if (first_k >= 0 && k == first_k + 1) begin pc1 = s_ipc; w1 = s_instr; end
            if (first_k < 0 && s_iv) begin first_k = k; pc0 = s_ipc; w0 = s_instr; end
        end
        chk("first_valid_latency", 32'(first_k), 32'd3);
        chk("first_pc", pc0, 32'h0000_0000);
        chk("first_word", w0, 32'h5A5A_A5A5);
        chk("second_pc", pc1, 32'h0000_0004);
        chk("second_word", w1, 32'h5A5E_A5A5);

        // Decode stalled: credit stops requests after exactly DEPTH.
        p_instr = 0;
        doReset(2);
        fires = 0;
        repeat (15) begin
            applyStimulus();
            if (s_rv && bus.req_ready) fires++;
        end
        chk("credit_fires", 32'(fires), 32'd4);
        chk("full_valid", {31'h0, s_iv}, 32'd1);
        p_instr = 100;
        repeat (10) applyStimulus();

        // Redirect with words queued and responses in flight (latency 3).
        lat_min = 3; lat_max = 3; p_instr = 0;
        doReset(2);
        repeat (5) applyStimulus();
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        applyStimulus();
        p_instr = 100;
        applyStimulus();
        chk("redirect_flush", {31'h0, s_iv}, 32'd0);
        pc0 = '1; seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            applyStimulus();
            if (s_iv) begin pc0 = s_ipc; seen = 1; end
        end
        chk("redirect_first_pc", pc0, 32'h0000_0100);

        // PC wraps past the top of the address space.
        lat_min = 1; lat_max = 1;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        applyStimulus();
        pc0 = '1; pc1 = '1; seen = 0;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            applyStimulus();
            if (s_iv) begin
                if (seen == 0) pc0 = s_ipc; else pc1 = s_ipc;
                seen++;
            end
        end
        chk("wrap_pc0", pc0, 32'hFFFF_FFFC);
        chk("wrap_pc1", pc1, 32'h0000_0000);

        // Reset in mid-stream returns every output to its reset value.
        repeat (3) applyStimulus();
        doReset(1);
        applyStimulus();
        chk("rst_req_valid", {31'h0, s_rv}, 32'd0);
        chk("rst_req_addr", s_addr, 32'h0);
        chk("rst_instr_valid", {31'h0, s_iv}, 32'd0);
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_instr_pc", s_ipc, 32'h0);

`ifdef FETCH_STALL_CNT_EN
        p_fetch = 0; p_instr = 100;
        doReset(2);
        repeat (5) applyStimulus();
        applyStimulus();
        chk("stall_cnt_five", s_stall, 32'd5);
`endif

        // Random traffic with variable latency, redirects and occasional resets.
        p_fetch = 90; p_ready = 70; p_instr = 60; p_redir = 4; p_rst = 2;
        lat_min = 1; lat_max = 4;
        doReset(2);
        repeat (3000) applyStimulus();
        p_rst = 0; p_redir = 0;
        repeat (20) applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
